multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM that sits directly upstream of the datapath.
- Decodes `instrCode` and sequences the datapath's free-running pipeline registers (decode, execute, memory-access) through FETCH/DECODE/EXE/MEM/WB steps.
- Drives every datapath control input, plus the data-bus write strobe and access size.

Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (asserted when 0)
- instrCode  in  32  current instruction from instruction memory, addressed by the PC
- PCEn  out  1  PC register load enable
- regFileWe  out  1  register-file write enable
- aluControl  out  4  ALU operation, encoded as {funct7[5], funct3}
- aluSrcMuxSel  out  1  ALU B operand select: 0 = rs2, 1 = immediate
- RFWDSrcMuxSel  out  3  write-back select: 0 = alu, 1 = mem, 2 = imm, 3 = PC+imm, 4 = PC+4
- branch  out  1  instruction is a B-type branch
- jal  out  1  unconditional jump (JAL or JALR)
- jalr  out  1  PC+imm adder uses rs1 instead of PC
- busWe  out  1  data-bus write strobe
- busSize  out  2  access size: 00 = byte, 01 = half, 10 = word (funct3[1:0])
- illegalInstr  out  1  one-cycle pulse when an unsupported opcode reaches EXE

Behaviour:
- States: FETCH, DECODE, EXE, MEM_S, MEM_L, WB_L.
- reset = 0 at a clk edge: state <= FETCH. All outputs are registered-state decodes, so every output is 0 while in FETCH after reset, except PCEn = 1.
- FETCH:
  - PCEn = 1; PC loads the execute-stage next-PC latched during the previous cycle.
  - All other outputs 0.
  - Next state: DECODE.
  - On the first FETCH after reset the execute-stage register still holds 0, so PC stays 0.
- DECODE:
  - The new instruction is present; the datapath decode registers capture rs1, rs2 and imm at the end of this cycle.
  - All write strobes are 0.
  - Next state: EXE.
- Decoded controls (aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr, busSize) are pure functions of `instrCode`. They are driven in DECODE, EXE, MEM_S, MEM_L and WB_L, and held constant for the whole instruction.
- EXE, per opcode:
  - R (0110011): aluControl = {f7[5], f3}; aluSrc = 0; RFWD = 0; regFileWe = 1. Next: FETCH.
  - I-ALU (0010011): aluSrc = 1; aluControl = {f7[5] only if f3 = 101 else 0, f3}; RFWD = 0; regFileWe = 1. Next: FETCH.
  - LUI (0110111): RFWD = 2; regFileWe = 1. Next: FETCH.
  - AUIPC (0010111): RFWD = 3; regFileWe = 1. Next: FETCH.
  - JAL (1101111): jal = 1; RFWD = 4; regFileWe = 1. Next: FETCH.
  - JALR (1100111): jal = 1; jalr = 1; RFWD = 4; regFileWe = 1. Next: FETCH.
  - B (1100011): branch = 1; aluSrc = 0; aluControl = {0, f3}; no write. Next: FETCH.
  - S (0100011): aluSrc = 1; aluControl = ADD (0000); no write. Next: MEM_S.
  - L (0000011): aluSrc = 1; aluControl = ADD; no write. Next: MEM_L.
  - Any other opcode: no writes; illegalInstr = 1 for this cycle; treated as a NOP (PC+4). Next: FETCH.
- MEM_S: busWe = 1; busSize = f3[1:0]; address and data come from the datapath execute registers. Next: FETCH.
- MEM_L: busWe = 0; load data is captured into the memory-access register at the end of the cycle. Next: WB_L.
- WB_L: RFWD = 1; regFileWe = 1. Next: FETCH.
- Instruction latency:
  - 3 cycles: R, I, U, J, B and illegal.
  - 4 cycles: stores.
  - 5 cycles: loads.
- PCEn is 1 only in FETCH. regFileWe and busWe are never 1 in the same cycle.
- Because controls are held through the tail states, the next-PC recomputed in MEM/WB equals the value computed in EXE.
- reset = 0 in any state (including MEM_S) forces FETCH at that edge. busWe and regFileWe go to 0 in the following cycle; no partial write extends past the reset edge.
- Reserved funct3 values (S: f3 ≥ 011; L: f3 = 011, 110, 111) still sequence normally. busSize = f3[1:0]; these are not flagged as illegal.

Test Plan:
- Reset low 2 cycles, then high → state FETCH with PCEn = 1 and all other outputs 0; then DECODE, then EXE on successive cycles.
- `add x3, x1, x2` (0x002081B3) → EXE: regFileWe = 1, aluControl = 0000, aluSrc = 0, RFWD = 0; FETCH 3 cycles after the previous FETCH.
- `sub`/`srai` (0x40208233 / 0x4020D213) → aluControl = 1000 / 1101; srai has aluSrc = 1.
- `sb x2, 3(x1)` (0x002081A3) → MEM_S with busWe = 1, busSize = 00; next FETCH 4 cycles after the previous FETCH; regFileWe = 0 throughout.
- `lw x5, 8(x1)` (0x0080A283) → MEM_L with busWe = 0, then WB_L with regFileWe = 1 and RFWD = 1; 5-cycle period.
- `beq` (0x00208463) → branch = 1, aluControl = 0000, no writes. `jalr x1, 4(x2)` (0x004100E7) → jal = 1, jalr = 1, RFWD = 4, regFileWe = 1.
- Opcode 0x7F → illegalInstr pulses 1 cycle in EXE, no writes. reset = 0 during MEM_S → FETCH next cycle with busWe = 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM (master) and the RV32I datapath (slave).
// There is no valid/ready handshake: the instruction word is valid whenever the FSM is past FETCH,
// and each control output is valid for the cycle in which it is driven.
interface multicycle_control_unit_if;
    logic [31:0] instrCode;
    logic        PCEn;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic [2:0]  RFWDSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        busWe;
    logic [1:0]  busSize;
    logic        illegalInstr;
    logic [2:0]  state_dbg;

    modport master (
        input  instrCode,
        output PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
        output branch, jal, jalr, busWe, busSize, illegalInstr, state_dbg
    );

    modport slave (
        output instrCode,
        input  PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
        input  branch, jal, jalr, busWe, busSize, illegalInstr, state_dbg
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: decodes instrCode and steps the datapath through
// FETCH/DECODE/EXE and the store/load tail states. All outputs decode the registered state.
module multicycle_control_unit (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_control_unit_if.master      bus
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXE    = 3'd2;
    localparam logic [2:0] MEM_S  = 3'd3;
    localparam logic [2:0] MEM_L  = 3'd4;
    localparam logic [2:0] WB_L   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;

    logic [2:0] state;
    logic [2:0] state_next;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;

    logic [3:0] dec_alu;
    logic       dec_src;
    logic [2:0] dec_rfwd;
    logic       dec_branch;
    logic       dec_jal;
    logic       dec_jalr;
    logic [1:0] dec_size;
    logic       dec_exe_we;
    logic       dec_legal;
    logic [2:0] dec_exe_next;

    assign opcode = bus.instrCode[6:0];
    assign f3     = bus.instrCode[14:12];
    assign f7b5   = bus.instrCode[30];

    // Instruction-level decode; held for the whole instruction since instrCode is stable.
    always_comb begin
        dec_alu      = 4'b0000;
        dec_src      = 1'b0;
        dec_rfwd     = 3'd0;
        dec_branch   = 1'b0;
        dec_jal      = 1'b0;
        dec_jalr     = 1'b0;
        dec_size     = 2'b00;
        dec_exe_we   = 1'b0;
        dec_legal    = 1'b1;
        dec_exe_next = FETCH;
        case (opcode)
            OP_R: begin
                dec_alu    = {f7b5, f3};
                dec_exe_we = 1'b1;
            end
            OP_I: begin
                // Bit 30 is an immediate bit except for the shift-right encodings.
                dec_alu    = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
                dec_src    = 1'b1;
                dec_exe_we = 1'b1;
            end
            OP_LUI: begin
                dec_rfwd   = 3'd2;
                dec_exe_we = 1'b1;
            end
            OP_AUIPC: begin
                dec_rfwd   = 3'd3;
                dec_exe_we = 1'b1;
            end
            OP_JAL: begin
                dec_jal    = 1'b1;
                dec_rfwd   = 3'd4;
                dec_exe_we = 1'b1;
            end
            OP_JALR: begin
                dec_jal    = 1'b1;
                dec_jalr   = 1'b1;
                dec_rfwd   = 3'd4;
                dec_exe_we = 1'b1;
            end
            OP_B: begin
                dec_branch = 1'b1;
                dec_alu    = {1'b0, f3};
            end
            OP_S: begin
                dec_src      = 1'b1;
                dec_size     = f3[1:0];
                dec_exe_next = MEM_S;
            end
            OP_L: begin
                dec_src      = 1'b1;
                dec_size     = f3[1:0];
                dec_rfwd     = 3'd1;
                dec_exe_next = MEM_L;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE:  state_next = EXE;
            EXE:     state_next = dec_exe_next;
            MEM_L:   state_next = WB_L;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        bus.PCEn          = 1'b0;
        bus.regFileWe     = 1'b0;
        bus.busWe         = 1'b0;
        bus.illegalInstr  = 1'b0;
        bus.aluControl    = 4'b0000;
        bus.aluSrcMuxSel  = 1'b0;
        bus.RFWDSrcMuxSel = 3'd0;
        bus.branch        = 1'b0;
        bus.jal           = 1'b0;
        bus.jalr          = 1'b0;
        bus.busSize       = 2'b00;
        if (state == FETCH) begin
            bus.PCEn = 1'b1;
        end else begin
            bus.aluControl    = dec_alu;
            bus.aluSrcMuxSel  = dec_src;
            bus.RFWDSrcMuxSel = dec_rfwd;
            bus.branch        = dec_branch;
            bus.jal           = dec_jal;
            bus.jalr          = dec_jalr;
            bus.busSize       = dec_size;
        end
        case (state)
            EXE: begin
                bus.regFileWe    = dec_exe_we;
                bus.illegalInstr = ~dec_legal;
            end
            MEM_S:   bus.busWe     = 1'b1;
            WB_L:    bus.regFileWe = 1'b1;
            default: ;
        endcase
    end

    assign bus.state_dbg = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-state control vectors and instruction periods.
module tb_multicycle_control_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   both_we;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM_S  = 3'd3;
    localparam logic [2:0] S_MEM_L  = 3'd4;
    localparam logic [2:0] S_WB_L   = 3'd5;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && bus.regFileWe && bus.busWe) both_we++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Vector order: {PCEn, regFileWe, busWe, aluControl, aluSrc, RFWD, branch, jal, jalr, busSize, illegal}
    function automatic logic [16:0] ev(logic pc, logic rf, logic bw, logic [3:0] alu, logic src,
                                       logic [2:0] rfwd, logic br, logic j, logic jr,
                                       logic [1:0] bs, logic ill);
        return {pc, rf, bw, alu, src, rfwd, br, j, jr, bs, ill};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.PCEn, bus.regFileWe, bus.busWe, bus.aluControl, bus.aluSrcMuxSel,
                bus.RFWDSrcMuxSel, bus.branch, bus.jal, bus.jalr, bus.busSize, bus.illegalInstr};
    endfunction

    task automatic wait_fetch(inout int p);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            p++;
            guard++;
        end while (!bus.PCEn && guard < 20);
    endtask

    task automatic test_reset();
        int p;
        reset = 1'b0;
        bus.instrCode = 32'h0000_0013;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n_cmp++;
        if (dut_vec() !== ev(1,0,0,4'h0,0,3'd0,0,0,0,2'b00,0)) begin
            n_err++; $display("FAIL reset_vec: got %h want %h", dut_vec(), ev(1,0,0,4'h0,0,3'd0,0,0,0,2'b00,0));
        end
        n_cmp++;
        if (bus.state_dbg !== S_FETCH) begin
            n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, S_FETCH);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.state_dbg !== S_DECODE) begin
            n_err++; $display("FAIL reset_decode: got %0d want %0d", bus.state_dbg, S_DECODE);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.state_dbg !== S_EXE) begin
            n_err++; $display("FAIL reset_exe: got %0d want %0d", bus.state_dbg, S_EXE);
        end
        p = 2;
        wait_fetch(p);
    endtask

    task automatic test_alu();
        logic [31:0] instr [4];
        logic [16:0] exp_v [4];
        int p;
        instr[0] = 32'h002081B3; exp_v[0] = ev(0,1,0,4'b0000,0,3'd0,0,0,0,2'b00,0); // add
        instr[1] = 32'h40208233; exp_v[1] = ev(0,1,0,4'b1000,0,3'd0,0,0,0,2'b00,0); // sub
        instr[2] = 32'h4020D213; exp_v[2] = ev(0,1,0,4'b1101,1,3'd0,0,0,0,2'b00,0); // srai
        instr[3] = 32'hC0008093; exp_v[3] = ev(0,1,0,4'b0000,1,3'd0,0,0,0,2'b00,0); // addi -1024
        for (int i = 0; i < 4; i++) begin
            bus.instrCode = instr[i];
            @(negedge clk);
            n_cmp++;
            if (bus.regFileWe !== 1'b0 || bus.busWe !== 1'b0) begin
                n_err++; $display("FAIL alu_decode_we[%0d]: got rf=%b bw=%b want 0 0", i, bus.regFileWe, bus.busWe);
            end
            @(negedge clk);
            n_cmp++;
            if (dut_vec() !== exp_v[i]) begin
                n_err++; $display("FAIL alu_exe[%0d]: got %h want %h", i, dut_vec(), exp_v[i]);
            end
            p = 2;
            wait_fetch(p);
            n_cmp++;
            if (p !== 3) begin
                n_err++; $display("FAIL alu_period[%0d]: got %0d want 3", i, p);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] instr [2];
        logic [1:0]  size [2];
        int p;
        instr[0] = 32'h002081A3; size[0] = 2'b00; // sb
        instr[1] = 32'h0020B1A3; size[1] = 2'b11; // reserved f3=011
        for (int i = 0; i < 2; i++) begin
            bus.instrCode = instr[i];
            repeat (2) @(negedge clk);
            n_cmp++;
            if (dut_vec() !== ev(0,0,0,4'h0,1,3'd0,0,0,0,size[i],0)) begin
                n_err++; $display("FAIL store_exe[%0d]: got %h want %h", i, dut_vec(), ev(0,0,0,4'h0,1,3'd0,0,0,0,size[i],0));
            end
            @(negedge clk);
            n_cmp++;
            if (dut_vec() !== ev(0,0,1,4'h0,1,3'd0,0,0,0,size[i],0) || bus.state_dbg !== S_MEM_S) begin
                n_err++; $display("FAIL store_mem[%0d]: got %h st %0d want %h st 3", i, dut_vec(), bus.state_dbg, ev(0,0,1,4'h0,1,3'd0,0,0,0,size[i],0));
            end
            p = 3;
            wait_fetch(p);
            n_cmp++;
            if (p !== 4) begin
                n_err++; $display("FAIL store_period[%0d]: got %0d want 4", i, p);
            end
        end
    endtask

    task automatic test_load();
        int p;
        bus.instrCode = 32'h0080A283; // lw x5, 8(x1)
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== ev(0,0,0,4'h0,1,3'd1,0,0,0,2'b10,0)) begin
            n_err++; $display("FAIL load_exe: got %h want %h", dut_vec(), ev(0,0,0,4'h0,1,3'd1,0,0,0,2'b10,0));
        end
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== ev(0,0,0,4'h0,1,3'd1,0,0,0,2'b10,0) || bus.state_dbg !== S_MEM_L) begin
            n_err++; $display("FAIL load_mem: got %h st %0d want %h st 4", dut_vec(), bus.state_dbg, ev(0,0,0,4'h0,1,3'd1,0,0,0,2'b10,0));
        end
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== ev(0,1,0,4'h0,1,3'd1,0,0,0,2'b10,0) || bus.state_dbg !== S_WB_L) begin
            n_err++; $display("FAIL load_wb: got %h st %0d want %h st 5", dut_vec(), bus.state_dbg, ev(0,1,0,4'h0,1,3'd1,0,0,0,2'b10,0));
        end
        p = 4;
        wait_fetch(p);
        n_cmp++;
        if (p !== 5) begin
            n_err++; $display("FAIL load_period: got %0d want 5", p);
        end
    endtask

    task automatic test_control_flow();
        logic [31:0] instr [6];
        logic [16:0] exp_v [6];
        int p;
        instr[0] = 32'h00208463; exp_v[0] = ev(0,0,0,4'b0000,0,3'd0,1,0,0,2'b00,0); // beq
        instr[1] = 32'h40209463; exp_v[1] = ev(0,0,0,4'b0001,0,3'd0,1,0,0,2'b00,0); // bne, bit30 set
        instr[2] = 32'h004100E7; exp_v[2] = ev(0,1,0,4'b0000,0,3'd4,0,1,1,2'b00,0); // jalr
        instr[3] = 32'h008000EF; exp_v[3] = ev(0,1,0,4'b0000,0,3'd4,0,1,0,2'b00,0); // jal
        instr[4] = 32'h123450B7; exp_v[4] = ev(0,1,0,4'b0000,0,3'd2,0,0,0,2'b00,0); // lui
        instr[5] = 32'h00001097; exp_v[5] = ev(0,1,0,4'b0000,0,3'd3,0,0,0,2'b00,0); // auipc
        for (int i = 0; i < 6; i++) begin
            bus.instrCode = instr[i];
            repeat (2) @(negedge clk);
            n_cmp++;
            if (dut_vec() !== exp_v[i]) begin
                n_err++; $display("FAIL flow_exe[%0d]: got %h want %h", i, dut_vec(), exp_v[i]);
            end
            p = 2;
            wait_fetch(p);
            n_cmp++;
            if (p !== 3) begin
                n_err++; $display("FAIL flow_period[%0d]: got %0d want 3", i, p);
            end
        end
    endtask

    task automatic test_illegal();
        int p;
        bus.instrCode = 32'h0000007F;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== ev(0,0,0,4'h0,0,3'd0,0,0,0,2'b00,1)) begin
            n_err++; $display("FAIL illegal_exe: got %h want %h", dut_vec(), ev(0,0,0,4'h0,0,3'd0,0,0,0,2'b00,1));
        end
        p = 2;
        wait_fetch(p);
        n_cmp++;
        if (p !== 3 || bus.illegalInstr !== 1'b0) begin
            n_err++; $display("FAIL illegal_after: got period %0d ill %b want 3 0", p, bus.illegalInstr);
        end
    endtask

    task automatic test_reset_in_store();
        bus.instrCode = 32'h002081A3;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busWe !== 1'b1) begin
            n_err++; $display("FAIL rst_store_pre: got busWe %b want 1", bus.busWe);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== ev(1,0,0,4'h0,0,3'd0,0,0,0,2'b00,0) || bus.state_dbg !== S_FETCH) begin
            n_err++; $display("FAIL rst_store_post: got %h st %0d want %h st 0", dut_vec(), bus.state_dbg, ev(1,0,0,4'h0,0,3'd0,0,0,0,2'b00,0));
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [6];
        int          per [6];
        int p;
        instr[0] = 32'h002081B3; per[0] = 3;
        instr[1] = 32'h0080A283; per[1] = 5;
        instr[2] = 32'h002081A3; per[2] = 4;
        instr[3] = 32'h00208463; per[3] = 3;
        instr[4] = 32'h0000007F; per[4] = 3;
        instr[5] = 32'h0020A1A3; per[5] = 4;
        for (int i = 0; i < 6; i++) begin
            bus.instrCode = instr[i];
            p = 0;
            wait_fetch(p);
            n_cmp++;
            if (p !== per[i]) begin
                n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, p, per[i]);
            end
        end
        n_cmp++;
        if (both_we !== 0) begin
            n_err++; $display("FAIL we_exclusive: got %0d overlaps want 0", both_we);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        both_we = 0;
        reset   = 1'b0;
        bus.instrCode = 32'h0;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_control_flow();
        test_illegal();
        test_reset_in_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
